// File: rtl/sbtr_cntrl_mc.sv
// Multi-chain saboteur controller: streams descriptor bits into one selected SBTR chain,
// then drives the global fault trigger TFEn. Optional readback: define SBTR_READBACK_EN.
module sbtr_cntrl_mc #(
  parameter int NUM_CHAINS = 4,
  parameter int LEN_W      = 16,
  parameter int CNT_W      = 32,
  parameter int TGT_W      = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  STOP,
  input  logic [1:0]            FI_MODE,
  input  logic [TGT_W-1:0]      TARGET,
  input  logic [LEN_W-1:0]      SR_LEN,
  input  logic [CNT_W-1:0]      TIMEOUT,
  input  logic                  BIT_VALID,
  input  logic                  BIT_DATA,
  output logic                  BIT_READY,
  input  logic [NUM_CHAINS-1:0] SO,
  output logic [NUM_CHAINS-1:0] EN,
  output logic [NUM_CHAINS-1:0] SI,
  output logic                  TFEn,
  output logic                  DONE,
  output logic                  BUSY,
  output logic                  ERR
`ifdef SBTR_READBACK_EN
  ,
  output logic                  RB_PARITY,
  output logic [LEN_W-1:0]      RB_ONES
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              mode_reg, mode_next;
  logic [TGT_W-1:0]        tgt_reg, tgt_next;
  logic [LEN_W-1:0]        len_reg, len_next;
  logic [CNT_W-1:0]        tmo_reg, tmo_next;
  logic [LEN_W-1:0]        bits_reg, bits_next;
  logic [CNT_W-1:0]        run_cnt_reg, run_cnt_next;
  logic [NUM_CHAINS-1:0]   en_reg, en_next;
  logic [NUM_CHAINS-1:0]   si_reg, si_next;
  logic                    tfen_reg, tfen_next;
  logic                    done_reg, done_next;
  logic                    busy_reg, busy_next;
  logic                    err_reg, err_next;

  logic [NUM_CHAINS-1:0]   tgt_sel;
  logic                    start_ok;
  logic                    handshake;
  logic                    tfen_fire;
  logic [CNT_W-1:0]        tmo_minus1;

  // One-hot decode of the latched target chain.
  generate
    for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_sel
      assign tgt_sel[gi] = (tgt_reg == TGT_W'(gi));
    end
  endgenerate

  assign BIT_READY  = (state_reg == ST_LOAD) && (bits_reg < len_reg);
  assign handshake  = BIT_VALID && BIT_READY;
  assign start_ok   = START && !STOP && (state_reg == ST_IDLE);
  assign tmo_minus1 = tmo_reg - CNT_W'(1);

  // TFEn is registered, so it is decided one cycle early from the run counter.
  always_comb begin
    tfen_fire = 1'b0;
    case (mode_reg)
      2'd2:    tfen_fire = (tmo_reg != '0) && (run_cnt_reg == tmo_minus1);
      2'd3:    tfen_fire = (tmo_reg != '0) && (run_cnt_reg >= tmo_minus1);
      default: tfen_fire = 1'b1;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    tgt_next     = tgt_reg;
    len_next     = len_reg;
    tmo_next     = tmo_reg;
    bits_next    = bits_reg;
    run_cnt_next = run_cnt_reg;
    en_next      = '0;
    si_next      = si_reg;
    tfen_next    = 1'b0;
    done_next    = done_reg;
    err_next     = err_reg;
    if (STOP) begin
      state_next   = ST_IDLE;
      si_next      = '0;
      done_next    = 1'b0;
      bits_next    = '0;
      run_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            mode_next = FI_MODE;
            tgt_next  = TARGET;
            len_next  = SR_LEN;
            tmo_next  = TIMEOUT;
            bits_next = '0;
            err_next  = 1'b0;
            if (int'(TARGET) >= NUM_CHAINS) begin
              err_next = 1'b1;
            end else if (SR_LEN == '0) begin
              state_next   = ST_RUN;
              done_next    = 1'b1;
              run_cnt_next = '0;
            end else begin
              state_next = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (handshake) begin
            en_next   = tgt_sel;
            si_next   = tgt_sel & {NUM_CHAINS{BIT_DATA}};
            bits_next = bits_reg + LEN_W'(1);
          end else if (bits_reg == len_reg) begin
            // Final shift is on the chain this cycle; the run phase starts next.
            state_next   = ST_RUN;
            si_next      = '0;
            done_next    = 1'b1;
            run_cnt_next = '0;
          end
        end
        ST_RUN: begin
          if (run_cnt_reg != tmo_reg) begin
            run_cnt_next = run_cnt_reg + CNT_W'(1);
          end
          tfen_next = tfen_fire;
        end
        default: state_next = ST_IDLE;
      endcase
    end
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= ST_IDLE;
      mode_reg    <= '0;
      tgt_reg     <= '0;
      len_reg     <= '0;
      tmo_reg     <= '0;
      bits_reg    <= '0;
      run_cnt_reg <= '0;
      en_reg      <= '0;
      si_reg      <= '0;
      tfen_reg    <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      tgt_reg     <= tgt_next;
      len_reg     <= len_next;
      tmo_reg     <= tmo_next;
      bits_reg    <= bits_next;
      run_cnt_reg <= run_cnt_next;
      en_reg      <= en_next;
      si_reg      <= si_next;
      tfen_reg    <= tfen_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
      err_reg     <= err_next;
    end
  end

  assign EN   = en_reg;
  assign SI   = si_reg;
  assign TFEn = tfen_reg;
  assign DONE = done_reg;
  assign BUSY = busy_reg;
  assign ERR  = err_reg;

`ifdef SBTR_READBACK_EN
  logic             rb_par_reg, rb_par_next;
  logic [LEN_W-1:0] rb_ones_reg, rb_ones_next;
  logic             so_bit;

  // en_reg only ever holds the target bit, so masking selects SO[target].
  assign so_bit = |(SO & en_reg);

  always_comb begin
    rb_par_next  = rb_par_reg;
    rb_ones_next = rb_ones_reg;
    if (start_ok) begin
      rb_par_next  = 1'b0;
      rb_ones_next = '0;
    end else if (en_reg != '0) begin
      rb_par_next  = rb_par_reg ^ so_bit;
      rb_ones_next = rb_ones_reg + {{(LEN_W-1){1'b0}}, so_bit};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rb_par_reg  <= 1'b0;
      rb_ones_reg <= '0;
    end else begin
      rb_par_reg  <= rb_par_next;
      rb_ones_reg <= rb_ones_next;
    end
  end

  assign RB_PARITY = rb_par_reg;
  assign RB_ONES   = rb_ones_reg;
`else
  logic unused_rb;
  assign unused_rb = ^{SO, start_ok};
`endif

endmodule
